// File: rtl/tick_period_meter_if.sv
// Result channel of tick_period_meter: a held period measurement offered under
// valid/ready, plus the pulse that reports a result lost to back-pressure.
interface tick_period_meter_if #(
   parameter int COUNT_WIDTH = 16
);
   logic [COUNT_WIDTH-1:0] period;
   logic                   period_overflow;
   logic                   period_valid;
   logic                   period_ready;
   logic                   dropped;

   modport master (
      output period,
      output period_overflow,
      output period_valid,
      output dropped,
      input  period_ready
   );

   modport slave (
      input  period,
      input  period_overflow,
      input  period_valid,
      input  dropped,
      output period_ready
   );
endinterface

// File: rtl/tick_period_meter.sv
// Measures the clk-cycle spacing between rising edges of tick_in and hands each
// result to the consumer through a valid/ready holding register.
module tick_period_meter #(
   parameter int COUNT_WIDTH = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                tick_in,
   input  logic                enable,
   tick_period_meter_if.master res
);
   typedef enum logic [1:0] {IDLE, ARMED, MEASURING} state_t;

   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   history_q;
   logic                   synced;
   logic                   tick_edge;
   logic                   result_fire;
   logic [COUNT_WIDTH-1:0] count_q;
   logic [COUNT_WIDTH-1:0] period_q;
   logic                   overflow_q;
   logic                   valid_q;
   logic                   dropped_q;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         sync_q    <= '0;
         history_q <= 1'b0;
      end else begin
         sync_q[0] <= tick_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         history_q <= synced;
      end
   end

   assign synced      = sync_q[SYNC_STAGES-1];
   assign tick_edge   = synced & ~history_q;
   // An edge arriving while enable falls is deliberately not turned into a result.
   assign result_fire = (state == MEASURING) && enable && tick_edge;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state      <= IDLE;
         count_q    <= '0;
         period_q   <= '0;
         overflow_q <= 1'b0;
         valid_q    <= 1'b0;
         dropped_q  <= 1'b0;
      end else begin
         dropped_q <= 1'b0;

         case (state)
            IDLE: begin
               count_q <= '0;
               if (enable) begin
                  state <= ARMED;
               end
            end
            ARMED: begin
               if (!enable) begin
                  state   <= IDLE;
                  count_q <= '0;
               end else if (tick_edge) begin
                  state   <= MEASURING;
                  count_q <= COUNT_WIDTH'(1);
               end
            end
            MEASURING: begin
               if (!enable) begin
                  state   <= IDLE;
                  count_q <= '0;
               end else if (tick_edge) begin
                  count_q <= COUNT_WIDTH'(1);
               end else if (count_q != COUNT_MAX) begin
                  count_q <= count_q + COUNT_WIDTH'(1);
               end
            end
            default: begin
               state   <= IDLE;
               count_q <= '0;
            end
         endcase

         // A pending result that nobody is taking this cycle wins over the new one.
         if (result_fire) begin
            if (valid_q && !res.period_ready) begin
               dropped_q <= 1'b1;
            end else begin
               period_q   <= count_q;
               overflow_q <= (count_q == COUNT_MAX);
               valid_q    <= 1'b1;
            end
         end else if (valid_q && res.period_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign res.period          = period_q;
   assign res.period_overflow = overflow_q;
   assign res.period_valid    = valid_q;
   assign res.dropped         = dropped_q;
endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter: an event-time model predicts every output
// each cycle, and literal expectations pin the results of each scenario.
module tb_tick_period_meter;
   localparam int CW   = 4;
   localparam int SS   = 2;
   localparam int MAXV = (1 << CW) - 1;

   logic clk     = 1'b0;
   logic clr     = 1'b0;
   logic tick_in = 1'b0;
   logic enable  = 1'b0;

   tick_period_meter_if #(.COUNT_WIDTH(CW)) res_if ();

   tick_period_meter #(
      .COUNT_WIDTH(CW),
      .SYNC_STAGES(SS)
   ) dut (
      .clk     (clk),
      .clr     (clr),
      .tick_in (tick_in),
      .enable  (enable),
      .res     (res_if)
   );

   always #5 clk = ~clk;

   int checks       = 0;
   int errors       = 0;
   int drop_cnt     = 0;
   int valid_cycles = 0;
   int got_p[$];
   int got_o[$];

   bit th [SS+1];
   bit m_active = 1'b0;
   bit m_ref    = 1'b0;
   bit m_valid  = 1'b0;
   bit m_ovf    = 1'b0;
   bit m_drop   = 1'b0;
   bit m_edge   = 1'b0;
   bit m_res    = 1'b0;
   int m_last   = 0;
   int m_cyc    = 0;
   int m_period = 0;
   int m_val    = 0;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   task automatic check_result(input string name, input int idx, input int exp_p, input int exp_o);
      if (idx < got_p.size()) begin
         check_output({name, "_period"}, 32'(got_p[idx]), 32'(exp_p));
         check_output({name, "_overflow"}, 32'(got_o[idx]), 32'(exp_o));
      end else begin
         check_output({name, "_present"}, 32'(got_p.size()), 32'(idx + 1));
      end
   endtask

   task automatic clear_record();
      got_p.delete();
      got_o.delete();
      drop_cnt     = 0;
      valid_cycles = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tick_pulse();
      tick_in = 1'b1;
      @(negedge clk);
      tick_in = 1'b0;
   endtask

   task automatic tick_after(input int gap);
      idle(gap - 1);
      tick_pulse();
   endtask

   task automatic apply_stimulus(input int gap, input int n);
      tick_pulse();
      repeat (n) tick_after(gap);
   endtask

   // Model: events are rising tick_in samples seen SS cycles late; a result is the
   // cycle distance between consecutive events while enabled, capped at all-ones.
   initial begin
      forever begin
         @(posedge clk or negedge clr);
         if (!clr) begin
            foreach (th[i]) th[i] = 1'b0;
            m_active = 1'b0;
            m_ref    = 1'b0;
            m_valid  = 1'b0;
            m_ovf    = 1'b0;
            m_drop   = 1'b0;
            m_period = 0;
         end else begin
            m_edge = th[SS-1] && !th[SS];
            for (int i = SS; i > 0; i--) th[i] = th[i-1];
            th[0]  = tick_in;
            m_drop = 1'b0;
            m_res  = 1'b0;
            if (!m_active) begin
               if (enable) begin
                  m_active = 1'b1;
                  m_ref    = 1'b0;
               end
            end else if (!enable) begin
               m_active = 1'b0;
            end else if (m_edge) begin
               if (m_ref) begin
                  m_res = 1'b1;
                  m_val = (m_cyc - m_last > MAXV) ? MAXV : m_cyc - m_last;
               end
               m_ref  = 1'b1;
               m_last = m_cyc;
            end
            if (m_res) begin
               if (m_valid && !res_if.period_ready) begin
                  m_drop = 1'b1;
               end else begin
                  m_period = m_val;
                  m_ovf    = (m_val == MAXV);
                  m_valid  = 1'b1;
               end
            end else if (m_valid && res_if.period_ready) begin
               m_valid = 1'b0;
            end
            m_cyc++;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         #1;
         check_output("cmp_valid", 32'(res_if.period_valid), 32'(m_valid));
         check_output("cmp_dropped", 32'(res_if.dropped), 32'(m_drop));
         check_output("cmp_period", 32'(res_if.period), 32'(m_period));
         check_output("cmp_overflow", 32'(res_if.period_overflow), 32'(m_ovf));
         if (res_if.period_valid && res_if.period_ready) begin
            got_p.push_back(int'(res_if.period));
            got_o.push_back(int'(res_if.period_overflow));
         end
         if (res_if.dropped) drop_cnt++;
         if (res_if.period_valid) valid_cycles++;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      res_if.period_ready = 1'b0;
      @(negedge clk);
      #2;
      check_output("reset_valid", 32'(res_if.period_valid), 32'd0);
      check_output("reset_period", 32'(res_if.period), 32'd0);
      check_output("reset_overflow", 32'(res_if.period_overflow), 32'd0);
      check_output("reset_dropped", 32'(res_if.dropped), 32'd0);
      clr = 1'b1;
      @(negedge clk);

      $display("[TB] steady 5-cycle ticks");
      clear_record();
      res_if.period_ready = 1'b1;
      enable = 1'b1;
      idle(3);
      apply_stimulus(5, 5);
      idle(6);
      enable = 1'b0;
      idle(3);
      check_output("t1_count", 32'(got_p.size()), 32'd5);
      for (int i = 0; i < 5; i++) check_result($sformatf("t1_r%0d", i), i, 5, 0);
      check_output("t1_valid_cycles", 32'(valid_cycles), 32'd5);
      check_output("t1_drops", 32'(drop_cnt), 32'd0);

      $display("[TB] saturation then recovery");
      clear_record();
      enable = 1'b1;
      idle(3);
      tick_pulse();
      tick_after(20);
      tick_after(6);
      idle(6);
      enable = 1'b0;
      idle(3);
      check_output("t2_count", 32'(got_p.size()), 32'd2);
      check_result("t2_r0", 0, 15, 1);
      check_result("t2_r1", 1, 6, 0);

      $display("[TB] back-pressure drop");
      clear_record();
      res_if.period_ready = 1'b0;
      enable = 1'b1;
      idle(3);
      tick_pulse();
      tick_after(8);
      tick_after(9);
      idle(6);
      #1;
      check_output("t3_held_valid", 32'(res_if.period_valid), 32'd1);
      check_output("t3_held_period", 32'(res_if.period), 32'd8);
      check_output("t3_drops", 32'(drop_cnt), 32'd1);
      @(negedge clk);
      res_if.period_ready = 1'b1;
      @(negedge clk);
      res_if.period_ready = 1'b0;
      #1;
      check_output("t3_valid_falls", 32'(res_if.period_valid), 32'd0);
      enable = 1'b0;
      idle(3);
      check_output("t3_count", 32'(got_p.size()), 32'd1);
      check_result("t3_r0", 0, 8, 0);

      $display("[TB] accept and reload in one cycle");
      clear_record();
      enable = 1'b1;
      idle(3);
      tick_pulse();
      tick_after(8);
      idle(6);
      tick_pulse();
      @(negedge clk);
      #1;
      check_output("t4_pending_period", 32'(res_if.period), 32'd8);
      res_if.period_ready = 1'b1;
      @(negedge clk);
      res_if.period_ready = 1'b0;
      #1;
      check_output("t4_valid_stays", 32'(res_if.period_valid), 32'd1);
      check_output("t4_new_period", 32'(res_if.period), 32'd7);
      @(negedge clk);
      res_if.period_ready = 1'b1;
      idle(2);
      enable = 1'b0;
      idle(3);
      check_output("t4_count", 32'(got_p.size()), 32'd2);
      check_result("t4_r0", 0, 8, 0);
      check_result("t4_r1", 1, 7, 0);
      check_output("t4_drops", 32'(drop_cnt), 32'd0);

      $display("[TB] enable abort and re-arm");
      clear_record();
      enable = 1'b1;
      idle(3);
      tick_pulse();
      idle(4);
      enable = 1'b0;
      idle(3);
      enable = 1'b1;
      idle(2);
      apply_stimulus(10, 2);
      idle(6);
      enable = 1'b0;
      idle(3);
      check_output("t5_count", 32'(got_p.size()), 32'd2);
      check_result("t5_r0", 0, 10, 0);
      check_result("t5_r1", 1, 10, 0);
      check_output("t5_drops", 32'(drop_cnt), 32'd0);

      $display("[TB] async clear and held tick");
      clear_record();
      res_if.period_ready = 1'b0;
      enable = 1'b1;
      idle(3);
      apply_stimulus(6, 1);
      idle(5);
      #2;
      clr = 1'b0;
      #1;
      check_output("t6_clr_valid", 32'(res_if.period_valid), 32'd0);
      check_output("t6_clr_period", 32'(res_if.period), 32'd0);
      check_output("t6_clr_overflow", 32'(res_if.period_overflow), 32'd0);
      check_output("t6_clr_dropped", 32'(res_if.dropped), 32'd0);
      @(negedge clk);
      #2;
      clr = 1'b1;
      @(negedge clk);
      clear_record();
      res_if.period_ready = 1'b1;
      tick_in = 1'b1;
      idle(50);
      tick_in = 1'b0;
      idle(5);
      enable = 1'b0;
      idle(3);
      check_output("t6_count", 32'(got_p.size()), 32'd0);
      check_output("t6_valid_cycles", 32'(valid_cycles), 32'd0);
      check_output("t6_drops", 32'(drop_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
